// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between an instruction-fetch and a data requester.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; otherwise data always has priority.
module mem_port_arbiter #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FReq,
    input  logic [AddrWidth-1:0] FAddr,
    input  logic                 DReq,
    input  logic                 DWE,
    input  logic [AddrWidth-1:0] DAddr,
    input  logic [DataWidth-1:0] DWData,
    output logic                 FAck,
    output logic                 DAck,
    output logic [DataWidth-1:0] RData,
    output logic                 MemWE,
    output logic [AddrWidth-1:0] MemA,
    output logic [DataWidth-1:0] MemWD,
    input  logic [DataWidth-1:0] MemRD,
    output logic                 Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_data;
    logic   winner_data;

`ifdef MEM_PORT_ARB_RR_EN
    logic favour_fetch;

    // The pointer only matters on contention, so it moves only when both requesters collide.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            favour_fetch <= 1'b0;
        end else if (state == IDLE && FReq && DReq) begin
            favour_fetch <= grant_data;
        end
    end

    assign grant_data = DReq && !(FReq && favour_fetch);
`else
    assign grant_data = DReq;
`endif

    assign Busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (FReq || DReq) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MemWE doubles as the "this access is a write" flag while in ACCESS.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            FAck        <= 1'b0;
            DAck        <= 1'b0;
            MemWE       <= 1'b0;
            MemA        <= '0;
            MemWD       <= '0;
            RData       <= '0;
            winner_data <= 1'b0;
        end else begin
            FAck  <= 1'b0;
            DAck  <= 1'b0;
            MemWE <= 1'b0;
            case (state)
                IDLE: begin
                    if (FReq || DReq) begin
                        winner_data <= grant_data;
                        if (grant_data) begin
                            MemA  <= DAddr;
                            MemWD <= DWData;
                            MemWE <= DWE;
                        end else begin
                            MemA <= FAddr;
                        end
                    end
                end
                ACCESS: begin
                    if (!MemWE) begin
                        RData <= MemRD;
                    end
                    FAck <= !winner_data;
                    DAck <= winner_data;
                end
                default: ;
            endcase
        end
    end

endmodule
